id_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 29 ++
 rtl/id_stage_if.sv | 42 ++++
 rtl/id_regfile.sv | 47 ++++
 rtl/id_stage.sv | 191 +++++++++++++++++++
 tb/tb_id_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings and helpers for the decode stage and its neighbours.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [4:0]  REG_RA   = 5'd31;

    // Control-transfer class of the instruction sitting in IF/ID.
    typedef enum logic [2:0] {
        CT_NONE,
        CT_BEQ,
        CT_BNE,
        CT_J,
        CT_JAL,
        CT_JR
    } ctl_kind_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side handshake and ID/EX launch bundle of the decode stage.
interface id_stage_if;

    logic [31:0] inst_in;
    logic [31:0] pc_plus_4_in;

    logic        en;
    logic        Jmp;
    logic        Jal;
    logic        Jr;
    logic        Branch;
    logic [31:0] Addr_Beq;
    logic [31:0] Addr_Jmp;
    logic [31:0] Addr_Jr;

    logic        idex_valid;
    logic [31:0] idex_inst;
    logic [31:0] idex_pc_plus_4;
    logic [31:0] idex_rs_data;
    logic [31:0] idex_rt_data;
    logic [31:0] idex_imm;
    logic [4:0]  idex_rs;
    logic [4:0]  idex_rt;
    logic [4:0]  idex_rd;

    // Decode stage side
    modport master (
        input  inst_in, pc_plus_4_in,
        output en, Jmp, Jal, Jr, Branch, Addr_Beq, Addr_Jmp, Addr_Jr,
        output idex_valid, idex_inst, idex_pc_plus_4, idex_rs_data, idex_rt_data,
        output idex_imm, idex_rs, idex_rt, idex_rd
    );

    // Fetch / execute side
    modport slave (
        output inst_in, pc_plus_4_in,
        input  en, Jmp, Jal, Jr, Branch, Addr_Beq, Addr_Jmp, Addr_Jr,
        input  idex_valid, idex_inst, idex_pc_plus_4, idex_rs_data, idex_rt_data,
        input  idex_imm, idex_rs, idex_rt, idex_rd
    );

endinterface

// File: rtl/id_regfile.sv
// 32x32 register file: one write port, two write-first read ports, $0 reads zero.
module id_regfile #(
    parameter int unsigned DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);

    logic [31:0] regs [DEPTH];

    // Clear everything on reset; ignore writes to $0.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // Port A read with same-cycle write bypass.
    always_comb begin
        rdata_a = regs[raddr_a];
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && waddr == raddr_a) begin
            rdata_a = wdata;
        end
    end

    // Port B read with same-cycle write bypass.
    always_comb begin
        rdata_b = regs[raddr_b];
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && waddr == raddr_b) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID register, register file, branch/jump
// resolution, hazard stall and ID/EX launch.
module id_stage #(
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD,
    parameter int unsigned RF_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dest,
    input  logic        mem_reg_write,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_alu_data,
    id_stage_if.master  bus
);
    import mips_pkg::*;

    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    ctl_kind_e   ctl;
    logic        uses_rt;

    logic [31:0] rs_rf;
    logic [31:0] rt_rf;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mem_fwd_ok;

    logic        load_use;
    logic        ex_hit;
    logic        mem_hit;
    logic        stall;
    logic        flush;

    logic        jmp_c;
    logic        jal_c;
    logic        jr_c;
    logic        branch_c;

    logic        idex_valid_q;
    logic [31:0] idex_inst_q;
    logic [31:0] idex_pc4_q;
    logic [31:0] idex_rs_data_q;
    logic [31:0] idex_rt_data_q;
    logic [31:0] idex_imm_q;
    logic [4:0]  idex_rs_q;
    logic [4:0]  idex_rt_q;
    logic [4:0]  idex_rd_q;

    assign op    = ifid_inst[31:26];
    assign rs    = ifid_inst[25:21];
    assign rt    = ifid_inst[20:16];
    assign rd    = ifid_inst[15:11];
    assign funct = ifid_inst[5:0];
    assign imm   = sext16(ifid_inst[15:0]);

    assign uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);

    // Classify the IF/ID instruction's control-transfer kind.
    always_comb begin
        ctl = CT_NONE;
        case (op)
            OP_BEQ:   ctl = CT_BEQ;
            OP_BNE:   ctl = CT_BNE;
            OP_J:     ctl = CT_J;
            OP_JAL:   ctl = CT_JAL;
            OP_RTYPE: if (funct == FN_JR) ctl = CT_JR;
            default:  ctl = CT_NONE;
        endcase
    end

    id_regfile #(
        .DEPTH(RF_DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .rdata_a (rs_rf),
        .raddr_b (rt),
        .rdata_b (rt_rf)
    );

    // A MEM-stage ALU result overrides the regfile (and its WB bypass) for branch/jr use.
    assign mem_fwd_ok = mem_reg_write && !mem_mem_read && (mem_dest != '0);
    assign rs_val = (mem_fwd_ok && mem_dest == rs) ? mem_alu_data : rs_rf;
    assign rt_val = (mem_fwd_ok && mem_dest == rt) ? mem_alu_data : rt_rf;

    assign load_use = ex_mem_read && (ex_dest != '0) &&
                      ((ex_dest == rs) || (uses_rt && ex_dest == rt));
    assign ex_hit   = ex_reg_write && (ex_dest != '0) &&
                      ((ex_dest == rs) || (uses_rt && ex_dest == rt));
    assign mem_hit  = mem_mem_read && (mem_dest != '0) &&
                      ((mem_dest == rs) || (uses_rt && mem_dest == rt));
    assign stall    = load_use ||
                      ((ctl == CT_BEQ || ctl == CT_BNE || ctl == CT_JR) && (ex_hit || mem_hit));

    // Control-transfer requests, suppressed while the stage is stalled.
    always_comb begin
        jmp_c    = 1'b0;
        jal_c    = 1'b0;
        jr_c     = 1'b0;
        branch_c = 1'b0;
        if (!stall) begin
            case (ctl)
                CT_J:    jmp_c    = 1'b1;
                CT_JAL:  jal_c    = 1'b1;
                CT_JR:   jr_c     = 1'b1;
                CT_BEQ:  branch_c = (rs_val == rt_val);
                CT_BNE:  branch_c = (rs_val != rt_val);
                default: ;
            endcase
        end
    end

    assign flush = jmp_c || jal_c || jr_c || branch_c;

    // IF/ID register: reset > stall hold > flush to NOP (PC+4 kept) > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_inst <= NOP_WORD;
            ifid_pc4  <= '0;
        end else if (!stall) begin
            if (flush) begin
                ifid_inst <= NOP_WORD;
            end else begin
                ifid_inst <= bus.inst_in;
                ifid_pc4  <= bus.pc_plus_4_in;
            end
        end
    end

    // ID/EX launch: bubble on stall, otherwise capture decode (jal links PC+4 into $31).
    always_ff @(posedge clk) begin
        if (rst || stall) begin
            idex_valid_q   <= 1'b0;
            idex_inst_q    <= rst ? '0 : NOP_WORD;
            idex_pc4_q     <= '0;
            idex_rs_data_q <= '0;
            idex_rt_data_q <= '0;
            idex_imm_q     <= '0;
            idex_rs_q      <= '0;
            idex_rt_q      <= '0;
            idex_rd_q      <= '0;
        end else begin
            idex_valid_q   <= (ifid_inst != NOP_WORD);
            idex_inst_q    <= ifid_inst;
            idex_pc4_q     <= ifid_pc4;
            idex_rs_data_q <= (ctl == CT_JAL) ? ifid_pc4 : rs_rf;
            idex_rt_data_q <= rt_rf;
            idex_imm_q     <= imm;
            idex_rs_q      <= rs;
            idex_rt_q      <= rt;
            idex_rd_q      <= (ctl == CT_JAL) ? REG_RA : rd;
        end
    end

    assign bus.en       = !stall;
    assign bus.Jmp      = jmp_c;
    assign bus.Jal      = jal_c;
    assign bus.Jr       = jr_c;
    assign bus.Branch   = branch_c;
    assign bus.Addr_Beq = ifid_pc4 + {imm[29:0], 2'b00};
    assign bus.Addr_Jmp = {ifid_pc4[31:28], ifid_inst[25:0], 2'b00};
    assign bus.Addr_Jr  = rs_val;

    assign bus.idex_valid     = idex_valid_q;
    assign bus.idex_inst      = idex_inst_q;
    assign bus.idex_pc_plus_4 = idex_pc4_q;
    assign bus.idex_rs_data   = idex_rs_data_q;
    assign bus.idex_rt_data   = idex_rt_data_q;
    assign bus.idex_imm       = idex_imm_q;
    assign bus.idex_rs        = idex_rs_q;
    assign bus.idex_rt        = idex_rt_q;
    assign bus.idex_rd        = idex_rd_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for the MIPS decode stage.
module tb_id_stage;
    import mips_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } idex_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_dest;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic [4:0]  mem_dest;
    logic [31:0] mem_alu_data;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_rf [32];
    idex_t sb [$];

    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage #(
        .NOP_WORD (32'h0000_0000),
        .RF_DEPTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_dest       (ex_dest),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .mem_dest      (mem_dest),
        .mem_alu_data  (mem_alu_data),
        .bus           (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        wb_we = 0; wb_addr = '0; wb_data = '0;
        ex_reg_write = 0; ex_mem_read = 0; ex_dest = '0;
        mem_reg_write = 0; mem_mem_read = 0; mem_dest = '0; mem_alu_data = '0;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc4);
        bus.inst_in = inst;
        bus.pc_plus_4_in = pc4;
    endtask

    function automatic idex_t observe();
        idex_t o;
        o.valid = bus.idex_valid; o.inst = bus.idex_inst; o.pc4 = bus.idex_pc_plus_4;
        o.rs_data = bus.idex_rs_data; o.rt_data = bus.idex_rt_data; o.imm = bus.idex_imm;
        o.rs = bus.idex_rs; o.rt = bus.idex_rt; o.rd = bus.idex_rd;
        return o;
    endfunction

    // Reference launch contents for an instruction with empty hazard inputs.
    function automatic idex_t model_launch(input logic [31:0] inst, input logic [31:0] pc4);
        idex_t e;
        e.valid = (inst != 32'h0);
        e.inst = inst;
        e.pc4 = pc4;
        e.rs = inst[25:21];
        e.rt = inst[20:16];
        e.rd = inst[15:11];
        e.rs_data = (inst[25:21] == 5'd0) ? 32'h0 : model_rf[inst[25:21]];
        e.rt_data = (inst[20:16] == 5'd0) ? 32'h0 : model_rf[inst[20:16]];
        e.imm = {{16{inst[15]}}, inst[15:0]};
        if (inst[31:26] == 6'h03) begin
            e.rd = 5'd31;
            e.rs_data = pc4;
        end
        return e;
    endfunction

    task automatic test_reset;
        idex_t exp_v, got_v;
        rst = 1; clear_inputs(); drive(32'h1021_0003, 32'h10);
        tick(); tick();
        rst = 0; drive(32'h0, 32'h0);
        #1;
        for (int unsigned i = 0; i < 32; i++) model_rf[i] = '0;
        checks++;
        if (bus.en !== 1'b1) begin errors++; $display("FAIL reset_en got=%b exp=1", bus.en); end
        checks++;
        if ({bus.Jmp, bus.Jal, bus.Jr, bus.Branch} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl got=%b exp=0000", {bus.Jmp, bus.Jal, bus.Jr, bus.Branch});
        end
        exp_v = '0; got_v = observe();
        checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL reset_idex got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_branch;
        idex_t exp_v, got_v;
        clear_inputs();
        drive(32'h1021_0003, 32'h10);               // beq $1,$1,+3
        sb.push_back(model_launch(32'h1021_0003, 32'h10));
        tick();
        checks++;
        if (bus.Branch !== 1'b1) begin errors++; $display("FAIL beq_taken got=%b exp=1", bus.Branch); end
        checks++;
        if (bus.Addr_Beq !== 32'h1C) begin errors++; $display("FAIL beq_target got=%h exp=0000001c", bus.Addr_Beq); end
        drive(32'h2001_0005, 32'h14);
        sb.push_back(model_launch(32'h0, 32'h10));  // squashed slot keeps PC+4
        tick();
        exp_v = sb.pop_front(); got_v = observe();
        checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL beq_launch got=%h exp=%h", got_v, exp_v); end
        checks++;
        if (bus.Branch !== 1'b0) begin errors++; $display("FAIL flushed_branch got=%b exp=0", bus.Branch); end
        drive(32'h1421_0004, 32'h18);               // bne $1,$1 -> not taken
        tick();
        exp_v = sb.pop_front(); got_v = observe();
        checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL flush_nop got=%h exp=%h", got_v, exp_v); end
        checks++;
        if (bus.Branch !== 1'b0) begin errors++; $display("FAIL bne_not_taken got=%b exp=0", bus.Branch); end
        drive(32'h1040_0001, 32'h1C);               // beq $2,$0,+1
        tick();
        mem_mem_read = 1; mem_dest = 5'd2;
        #1;
        checks++;
        if ({bus.en, bus.Branch} !== 2'b00) begin
            errors++; $display("FAIL beq_mem_load_stall got=%b exp=00", {bus.en, bus.Branch});
        end
        tick();
        mem_mem_read = 0; mem_dest = '0;
        #1;
        checks++;
        if ({bus.en, bus.Branch} !== 2'b11) begin
            errors++; $display("FAIL beq_after_stall got=%b exp=11", {bus.en, bus.Branch});
        end
        drive(32'h0, 32'h20);
        tick(); tick();
    endtask

    task automatic test_load_use;
        idex_t exp_v, got_v;
        clear_inputs();
        drive(32'h00A6_1820, 32'h20);               // add $3,$5,$6
        tick();
        ex_mem_read = 1; ex_dest = 5'd5;
        drive(32'h00E0_2020, 32'h24);               // add $4,$7,$0
        #1;
        checks++;
        if (bus.en !== 1'b0) begin errors++; $display("FAIL load_use_en got=%b exp=0", bus.en); end
        tick();
        checks++;
        if ({bus.idex_valid, bus.idex_inst} !== 33'h0) begin
            errors++; $display("FAIL load_use_bubble got=%b/%h exp=0/00000000", bus.idex_valid, bus.idex_inst);
        end
        ex_mem_read = 0; ex_dest = '0;
        #1;
        checks++;
        if (bus.en !== 1'b1) begin errors++; $display("FAIL load_use_release got=%b exp=1", bus.en); end
        sb.push_back(model_launch(32'h00A6_1820, 32'h20));
        tick();
        exp_v = sb.pop_front(); got_v = observe();
        checks++;
        if (got_v !== exp_v || bus.idex_rs !== 5'd5) begin
            errors++; $display("FAIL load_use_launch got=%h exp=%h", got_v, exp_v);
        end
        sb.push_back(model_launch(32'h00E0_2020, 32'h24));
        drive(32'h0, 32'h28);
        tick();
        exp_v = sb.pop_front(); got_v = observe();
        checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL load_use_next got=%h exp=%h", got_v, exp_v); end
        tick();
    endtask

    task automatic test_jr;
        clear_inputs();
        drive(32'h03E0_0008, 32'h30);               // jr $31
        tick();
        ex_reg_write = 1; ex_dest = 5'd31;
        #1;
        checks++;
        if ({bus.en, bus.Jr} !== 2'b00) begin errors++; $display("FAIL jr_ex_stall got=%b exp=00", {bus.en, bus.Jr}); end
        tick();
        ex_reg_write = 0; ex_dest = '0;
        mem_reg_write = 1; mem_dest = 5'd31; mem_alu_data = 32'h40;
        #1;
        checks++;
        if ({bus.en, bus.Jr} !== 2'b11) begin errors++; $display("FAIL jr_fwd_ctl got=%b exp=11", {bus.en, bus.Jr}); end
        checks++;
        if (bus.Addr_Jr !== 32'h40) begin errors++; $display("FAIL jr_fwd_addr got=%h exp=00000040", bus.Addr_Jr); end
        drive(32'h00E0_2020, 32'h34);
        tick();
        clear_inputs();
        #1;
        checks++;
        if ({bus.idex_valid, bus.idex_inst, bus.Jr} !== {1'b1, 32'h03E0_0008, 1'b0}) begin
            errors++; $display("FAIL jr_launch got=%b/%h/%b exp=1/03e00008/0", bus.idex_valid, bus.idex_inst, bus.Jr);
        end
        drive(32'h0, 32'h38);
        tick();
        checks++;
        if (bus.idex_valid !== 1'b0) begin errors++; $display("FAIL jr_squash got=%b exp=0", bus.idex_valid); end
        tick();
    endtask

    task automatic test_wb_bypass;
        clear_inputs();
        drive(32'h00E0_1820, 32'h40);               // add $3,$7,$0
        tick();
        wb_we = 1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF;
        drive(32'h0007_1820, 32'h44);               // add $3,$0,$7
        tick();
        model_rf[7] = 32'hDEAD_BEEF;
        checks++;
        if (bus.idex_rs_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wb_bypass got=%h exp=deadbeef", bus.idex_rs_data);
        end
        wb_addr = 5'd0; wb_data = 32'h0000_1234;
        drive(32'h0000_1820, 32'h48);               // add $3,$0,$0
        tick();
        checks++;
        if ({bus.idex_rs_data, bus.idex_rt_data} !== {32'h0, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL wb_zero_bypass got=%h/%h exp=00000000/deadbeef", bus.idex_rs_data, bus.idex_rt_data);
        end
        wb_we = 0;
        drive(32'h0, 32'h4C);
        tick();
        checks++;
        if ({bus.idex_rs_data, bus.idex_rt_data} !== 64'h0) begin
            errors++; $display("FAIL wb_zero_store got=%h/%h exp=0/0", bus.idex_rs_data, bus.idex_rt_data);
        end
        tick();
    endtask

    task automatic test_jal;
        idex_t exp_v, got_v;
        clear_inputs();
        drive(32'h0C00_0100, 32'h8000_0004);        // jal 26'h100
        sb.push_back(model_launch(32'h0C00_0100, 32'h8000_0004));
        tick();
        checks++;
        if ({bus.Jal, bus.Jmp} !== 2'b10) begin errors++; $display("FAIL jal_ctl got=%b exp=10", {bus.Jal, bus.Jmp}); end
        checks++;
        if (bus.Addr_Jmp !== 32'h8000_0400) begin errors++; $display("FAIL jal_target got=%h exp=80000400", bus.Addr_Jmp); end
        drive(32'h0800_0010, 32'h100);              // j 26'h10, squashed
        tick();
        exp_v = sb.pop_front(); got_v = observe();
        checks++;
        if (got_v !== exp_v || bus.idex_rd !== 5'd31) begin
            errors++; $display("FAIL jal_link got=%h exp=%h", got_v, exp_v);
        end
        tick();
        checks++;
        if ({bus.Jmp, bus.Addr_Jmp} !== {1'b1, 32'h0000_0040}) begin
            errors++; $display("FAIL j_target got=%b/%h exp=1/00000040", bus.Jmp, bus.Addr_Jmp);
        end
        drive(32'h0, 32'h104);
        tick(); tick();
    endtask

    task automatic test_back_to_back;
        idex_t exp_v, got_v;
        logic [5:0]  ops [4] = '{6'h00, 6'h08, 6'h23, 6'h2B};
        logic [5:0]  fns [4] = '{6'h20, 6'h22, 6'h25, 6'h2A};
        logic [4:0]  regs [3] = '{5'd0, 5'd3, 5'd7};
        logic [31:0] inst;
        clear_inputs();
        for (int unsigned i = 0; i <= 16; i++) begin
            if (i < 16) begin
                inst = {ops[$urandom_range(0, 3)], regs[$urandom_range(0, 2)], regs[$urandom_range(0, 2)],
                        16'($urandom)};
                if (inst[31:26] == 6'h00) inst[5:0] = fns[$urandom_range(0, 3)];
                drive(inst, 32'h1000 + 32'(4 * i));
                sb.push_back(model_launch(inst, 32'h1000 + 32'(4 * i)));
            end else begin
                drive(32'h0, 32'h2000);
            end
            tick();
            if (i >= 1) begin
                exp_v = sb.pop_front(); got_v = observe();
                checks++;
                if (got_v !== exp_v) begin errors++; $display("FAIL b2b_%0d got=%h exp=%h", i, got_v, exp_v); end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_stall;
        idex_t exp_v, got_v;
        clear_inputs();
        drive(32'h00E7_3820, 32'h50);               // add $7,$7,$7
        tick();
        ex_mem_read = 1; ex_dest = 5'd7;
        #1;
        checks++;
        if (bus.en !== 1'b0) begin errors++; $display("FAIL pre_reset_stall got=%b exp=0", bus.en); end
        rst = 1;
        tick();
        rst = 0;
        for (int unsigned i = 0; i < 32; i++) model_rf[i] = '0;
        #1;
        checks++;
        if ({bus.en, bus.Jmp, bus.Jal, bus.Jr, bus.Branch} !== 5'b10000) begin
            errors++; $display("FAIL rst_stall_ctl got=%b exp=10000", {bus.en, bus.Jmp, bus.Jal, bus.Jr, bus.Branch});
        end
        exp_v = '0; got_v = observe();
        checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL rst_stall_idex got=%h exp=%h", got_v, exp_v); end
        clear_inputs();
        sb.push_back(model_launch(32'h00E7_3820, 32'h54));
        drive(32'h00E7_3820, 32'h54);
        tick();
        drive(32'h0, 32'h58);
        tick();
        exp_v = sb.pop_front(); got_v = observe();
        checks++;
        if (got_v !== exp_v || bus.idex_rs_data !== 32'h0) begin
            errors++; $display("FAIL rst_regs_zero got=%h exp=%h", got_v, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst = 1;
        drive(32'h0, 32'h0);
        test_reset();
        test_branch();
        test_load_use();
        test_jr();
        test_wb_bypass();
        test_jal();
        test_back_to_back();
        test_reset_mid_stall();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
